// File: rtl/dmem_pkg.sv
// Shared types and helpers for the sized data memory.
// Size codes, FSM states and the alignment check.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Illegal size is treated as a misalignment
  function automatic logic is_misaligned(
    input logic [1:0] size,
    input logic [1:0] addr_lo
  );
    return (size == SZ_ILL)
        || ((size == SZ_HALF) && addr_lo[0])
        || ((size == SZ_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Big-endian byte-lane steering for stores and loads.
// Lane k is the byte at word-aligned base + k.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        sgn,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wlane,
  output logic [31:0] rdata
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // Lane enables, replicated store data and extended load data
  always_comb begin
    be    = 4'b0000;
    wlane = 32'd0;
    rdata = 32'd0;
    rbyte = 8'd0;
    unique case (off)
      2'd0: rbyte = rword[31:24];
      2'd1: rbyte = rword[23:16];
      2'd2: rbyte = rword[15:8];
      2'd3: rbyte = rword[7:0];
      default: rbyte = 8'd0;
    endcase
    rhalf = off[1] ? rword[15:0] : rword[31:16];
    unique case (1'b1)
      size == SZ_BYTE: begin
        be    = 4'b0001 << off;
        wlane = {4{wdata[7:0]}};
        rdata = {{24{sgn & rbyte[7]}}, rbyte};
      end
      size == SZ_HALF: begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata[15:0]}};
        rdata = {{16{sgn & rhalf[15]}}, rhalf};
      end
      size == SZ_WORD: begin
        be    = 4'b1111;
        wlane = wdata;
        rdata = rword;
      end
      default: begin
        be    = 4'b0000;
        wlane = 32'd0;
        rdata = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_sized.sv
// Multi-cycle byte/half/word data memory, big-endian.
// Req/Ready handshake with configurable wait states.
module data_mem_sized
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        Req,
  output logic        Ready,
  input  logic        WR,
  input  logic [1:0]  Size,
  input  logic        Signed,
  input  logic [31:0] DAddr,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        Valid,
  output logic        Done,
  output logic        AlignErr
);

  localparam logic [3:0] CNT_LOAD =
    (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  dmem_state_t       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rdy_q, rdy_d;
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic              sgn_q, sgn_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       din_q, din_d;
  logic              err_q, err_d;
  logic [31:0]       dout_q, dout_d;

  logic [7:0]        mem_q [2**ADDR_W];

  logic              accept;
  logic              err_now;
  logic              commit;
  logic              cur_wr;
  logic [1:0]        cur_size;
  logic              cur_sgn;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       cur_din;
  logic [ADDR_W-1:0] lane_addr [4];
  logic [31:0]       rword;
  logic [3:0]        be;
  logic [31:0]       wlane;
  logic [31:0]       rdata;

  assign accept  = rdy_q && (state_q == IDLE) && Req;
  assign err_now = is_misaligned(Size, DAddr[1:0])
                || ((DAddr >> ADDR_W) != 32'd0);

  // With no wait states the access uses the live inputs
  assign cur_wr   = (state_q == IDLE) ? WR : wr_q;
  assign cur_size = (state_q == IDLE) ? Size : size_q;
  assign cur_sgn  = (state_q == IDLE) ? Signed : sgn_q;
  assign cur_addr = (state_q == IDLE) ? DAddr[ADDR_W-1:0] : addr_q;
  assign cur_din  = (state_q == IDLE) ? DataIn : din_q;

  assign commit = (accept && !err_now && (WAIT_CYCLES == 0))
               || ((state_q == WAIT) && (cnt_q == 4'd0));

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_lane
      assign lane_addr[g] = {cur_addr[ADDR_W-1:2], 2'(g)};
      assign rword[31-8*g -: 8] = mem_q[lane_addr[g]];
    end
  endgenerate

  dmem_lane_align u_align (
    .size  (cur_size),
    .off   (cur_addr[1:0]),
    .sgn   (cur_sgn),
    .wdata (cur_din),
    .rword (rword),
    .be    (be),
    .wlane (wlane),
    .rdata (rdata)
  );

  // Next-state, request latch and load result
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdy_d   = 1'b1;
    wr_d    = wr_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    addr_d  = addr_q;
    din_d   = din_q;
    err_d   = err_q;
    dout_d  = dout_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          wr_d   = WR;
          size_d = Size;
          sgn_d  = Signed;
          addr_d = DAddr[ADDR_W-1:0];
          din_d  = DataIn;
          err_d  = err_now;
          if (err_now || (WAIT_CYCLES == 0)) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else cnt_d = cnt_q - 4'd1;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (commit && !cur_wr) dout_d = rdata;
  end

  // Control and request registers
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdy_q   <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      sgn_q   <= 1'b0;
      addr_q  <= '0;
      din_q   <= 32'd0;
      err_q   <= 1'b0;
      dout_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
    end
  end

  // Byte-array RAM, written on the edge entering RESP
  always_ff @(posedge clk) begin
    if (commit && cur_wr) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem_q[lane_addr[k]] <= wlane[31-8*k -: 8];
      end
    end
  end

  assign Ready    = rdy_q && (state_q == IDLE);
  assign Valid    = (state_q == RESP) && !err_q && !wr_q;
  assign Done     = (state_q == RESP) && !err_q && wr_q;
  assign AlignErr = (state_q == RESP) && err_q;
  assign DataOut  = dout_q;

endmodule

// File: tb/tb_data_mem_sized.sv
// Directed bench for data_mem_sized.
// One instance with 1 wait state, one with 3.
module tb_data_mem_sized;

  logic        clk = 1'b0;
  logic        Reset;
  logic        WR;
  logic [1:0]  Size;
  logic        Signed;
  logic [31:0] DAddr;
  logic [31:0] DataIn;
  logic        Req1, Req3;
  logic        Ready1, Valid1, Done1, Err1;
  logic        Ready3, Valid3, Done3, Err3;
  logic [31:0] Dout1, Dout3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  data_mem_sized #(.ADDR_W(8), .WAIT_CYCLES(1)) u1 (
    .clk(clk), .Reset(Reset), .Req(Req1), .Ready(Ready1),
    .WR(WR), .Size(Size), .Signed(Signed), .DAddr(DAddr),
    .DataIn(DataIn), .DataOut(Dout1), .Valid(Valid1),
    .Done(Done1), .AlignErr(Err1)
  );

  data_mem_sized #(.ADDR_W(8), .WAIT_CYCLES(3)) u3 (
    .clk(clk), .Reset(Reset), .Req(Req3), .Ready(Ready3),
    .WR(WR), .Size(Size), .Signed(Signed), .DAddr(DAddr),
    .DataIn(DataIn), .DataOut(Dout3), .Valid(Valid3),
    .Done(Done3), .AlignErr(Err3)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request and wait for its response pulse.
  // p = {Valid, Done, AlignErr}; lat = cycles after accept.
  task automatic acc(input bit s3, input logic wr, input logic [1:0] sz,
                     input logic sg, input logic [31:0] a,
                     input logic [31:0] d,
                     output logic [2:0] p, output int lat);
    int n;
    n = 0;
    while (!(s3 ? Ready3 : Ready1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    WR = wr; Size = sz; Signed = sg; DAddr = a; DataIn = d;
    if (s3) Req3 = 1'b1;
    else Req1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    Req1 = 1'b0;
    Req3 = 1'b0;
    p   = 3'b000;
    lat = 1;
    while (lat < 20) begin
      p = s3 ? {Valid3, Done3, Err3} : {Valid1, Done1, Err1};
      if (p != 3'b000) break;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic st(input string tag, input bit s3, input logic [1:0] sz,
                    input logic [31:0] a, input logic [31:0] d);
    logic [2:0] p;
    int lat;
    acc(s3, 1'b1, sz, 1'b0, a, d, p, lat);
    check({tag, ".pulse"}, 32'(p), 32'h2);
    check({tag, ".lat"}, 32'(lat), s3 ? 32'd4 : 32'd2);
  endtask

  task automatic ld(input string tag, input bit s3, input logic [1:0] sz,
                    input logic sg, input logic [31:0] a,
                    input logic [31:0] exp);
    logic [2:0] p;
    int lat;
    acc(s3, 1'b0, sz, sg, a, 32'd0, p, lat);
    check({tag, ".pulse"}, 32'(p), 32'h4);
    check({tag, ".lat"}, 32'(lat), s3 ? 32'd4 : 32'd2);
    check({tag, ".data"}, s3 ? Dout3 : Dout1, exp);
  endtask

  task automatic er(input string tag, input logic wr,
                    input logic [1:0] sz, input logic [31:0] a,
                    input logic [31:0] dout_keep);
    logic [2:0] p;
    int lat;
    acc(1'b0, wr, sz, 1'b0, a, 32'hDEADDEAD, p, lat);
    check({tag, ".pulse"}, 32'(p), 32'h1);
    check({tag, ".lat"}, 32'(lat), 32'd1);
    check({tag, ".dout"}, Dout1, dout_keep);
  endtask

  initial begin
    logic [14:0] rdy_vec;
    logic        done_seen;

    Reset = 1'b1; Req1 = 1'b0; Req3 = 1'b0;
    WR = 1'b0; Size = 2'b00; Signed = 1'b0;
    DAddr = 32'd0; DataIn = 32'd0;
    #2 Reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.ready", 32'(Ready1), 32'd0);
    check("rst.pulses", 32'({Valid1, Done1, Err1}), 32'd0);
    check("rst.dout", Dout1, 32'd0);
    Reset = 1'b1;
    @(negedge clk);
    check("rel.ready", 32'(Ready1), 32'd1);

    st("sw10", 1'b0, 2'b10, 32'h10, 32'h12345678);
    ld("lw10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h12345678);
    ld("lbu10", 1'b0, 2'b00, 1'b0, 32'h10, 32'h00000012);
    ld("lb13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h00000078);
    st("sb13", 1'b0, 2'b00, 32'h13, 32'h00000080);
    ld("lb13s", 1'b0, 2'b00, 1'b1, 32'h13, 32'hFFFFFF80);
    ld("lbu13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h00000080);
    ld("lw10b", 1'b0, 2'b10, 1'b0, 32'h10, 32'h12345680);

    st("sw20", 1'b0, 2'b10, 32'h20, 32'hCAFEF00D);
    st("sh22", 1'b0, 2'b01, 32'h22, 32'h1234BEEF);
    ld("lh22", 1'b0, 2'b01, 1'b1, 32'h22, 32'hFFFFBEEF);
    ld("lhu20", 1'b0, 2'b01, 1'b0, 32'h20, 32'h0000CAFE);
    ld("lw20", 1'b0, 2'b10, 1'b0, 32'h20, 32'hCAFEBEEF);

    er("sw11", 1'b1, 2'b10, 32'h11, 32'hCAFEBEEF);
    er("ld_sz3", 1'b0, 2'b11, 32'h10, 32'hCAFEBEEF);
    er("lw100", 1'b0, 2'b10, 32'h100, 32'hCAFEBEEF);
    er("lwFE", 1'b0, 2'b10, 32'hFE, 32'hCAFEBEEF);
    er("lh21", 1'b0, 2'b01, 32'h21, 32'hCAFEBEEF);
    ld("lw10c", 1'b0, 2'b10, 1'b0, 32'h10, 32'h12345680);

    st("swFC", 1'b0, 2'b10, 32'hFC, 32'hA1B2C3D4);
    ld("lwFC", 1'b0, 2'b10, 1'b0, 32'hFC, 32'hA1B2C3D4);
    ld("lbFF", 1'b0, 2'b00, 1'b1, 32'hFF, 32'hFFFFFFD4);

    // Continuous Req on the 3-wait-state instance
    WR = 1'b0; Size = 2'b10; Signed = 1'b0; DAddr = 32'h0;
    Req3 = 1'b1;
    for (int i = 0; i < 15; i++) begin
      rdy_vec[i] = Ready3;
      @(negedge clk);
    end
    Req3 = 1'b0;
    check("hs.ready_pattern", 32'(rdy_vec), 32'h0421);

    // Reset during WAIT abandons the store
    st("sw40", 1'b1, 2'b10, 32'h40, 32'h11223344);
    for (int i = 0; i < 10 && !Ready3; i++) @(negedge clk);
    WR = 1'b1; Size = 2'b10; DAddr = 32'h40; DataIn = 32'hAABBCCDD;
    Req3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    Req3 = 1'b0;
    check("wait.ready", 32'(Ready3), 32'd0);
    Reset = 1'b0;
    #1;
    check("rstw.done", 32'(Done3), 32'd0);
    check("rstw.dout1", Dout1, 32'd0);
    @(negedge clk);
    Reset = 1'b1;
    done_seen = 1'b0;
    @(negedge clk);
    check("rstw.ready", 32'(Ready3), 32'd1);
    for (int i = 0; i < 6; i++) begin
      done_seen = done_seen | Done3;
      @(negedge clk);
    end
    check("rstw.no_done", 32'(done_seen), 32'd0);
    ld("lw40", 1'b1, 2'b10, 1'b0, 32'h40, 32'h11223344);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
